// File: rtl/cmp_minmax_tracker.sv
// cmp_minmax_tracker: windowed running min/max tracker on a valid/ready stream.
// The compare is the 6-bit lt (signed) / ltu (unsigned) / eq relation of the upstream comparator.
// Optional build macro CMP_MINMAX_FLUSH_EN adds a 'flush' input that closes a window early.
module cmp_minmax_tracker #(
  parameter int WIDTH  = 6,
  parameter int WINDOW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CMP_MINMAX_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic             out_all_eq,
  output logic [7:0]       out_count,
  output logic             out_signed
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [7:0] WIN_CNT = 8'(WINDOW);

  logic [1:0]       state;
  logic [WIDTH-1:0] min_r;
  logic [WIDTH-1:0] max_r;
  logic [WIDTH-1:0] first_r;
  logic [7:0]       cnt;
  logic             all_eq_r;
  logic             mode_r;

  logic             flush_w;
  logic             accept;
  logic             lt_min;
  logic             lt_max;
  logic [WIDTH-1:0] nxt_min;
  logic [WIDTH-1:0] nxt_max;
  logic             nxt_eq;
  logic [7:0]       nxt_cnt;
  logic             nxt_mode;
  logic             close_win;

`ifdef CMP_MINMAX_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign in_ready = (state != HOLD);
  assign accept   = in_valid & in_ready;

  // Window statistics after the current sample (a first sample seeds them in IDLE)
  always_comb begin
    lt_min   = 1'b0;
    lt_max   = 1'b0;
    nxt_min  = min_r;
    nxt_max  = max_r;
    nxt_eq   = all_eq_r;
    nxt_cnt  = cnt;
    nxt_mode = mode_r;
    if (state == IDLE) begin
      nxt_min  = in_data;
      nxt_max  = in_data;
      nxt_eq   = 1'b1;
      nxt_cnt  = 8'd1;
      nxt_mode = signed_mode;
    end else begin
      if (mode_r) begin
        lt_min = $signed(in_data) < $signed(min_r);
        lt_max = $signed(max_r) < $signed(in_data);
      end else begin
        lt_min = in_data < min_r;
        lt_max = max_r < in_data;
      end
      if (accept) begin
        nxt_min = lt_min ? in_data : min_r;
        nxt_max = lt_max ? in_data : max_r;
        nxt_eq  = all_eq_r & (in_data == first_r);
        nxt_cnt = cnt + 8'd1;
      end
    end
  end

  // A window closes on its last sample, or early on flush (ignored in IDLE without a sample)
  always_comb begin
    close_win = 1'b0;
    if (accept && ((nxt_cnt == WIN_CNT) || flush_w))
      close_win = 1'b1;
    else if ((state == ACCUM) && flush_w)
      close_win = 1'b1;
  end

  // State machine, accumulators and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      min_r      <= '0;
      max_r      <= '0;
      first_r    <= '0;
      cnt        <= 8'd0;
      all_eq_r   <= 1'b0;
      mode_r     <= 1'b0;
      out_valid  <= 1'b0;
      out_min    <= '0;
      out_max    <= '0;
      out_all_eq <= 1'b0;
      out_count  <= 8'd0;
      out_signed <= 1'b0;
    end else begin
      if (state == HOLD) begin
        if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      end else begin
        if (accept) begin
          min_r    <= nxt_min;
          max_r    <= nxt_max;
          all_eq_r <= nxt_eq;
          cnt      <= nxt_cnt;
          mode_r   <= nxt_mode;
          if (state == IDLE)
            first_r <= in_data;
        end
        if (close_win) begin
          out_min    <= nxt_min;
          out_max    <= nxt_max;
          out_all_eq <= nxt_eq;
          out_count  <= nxt_cnt;
          out_signed <= nxt_mode;
          out_valid  <= 1'b1;
          state      <= HOLD;
        end else if (accept) begin
          state <= ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmp_minmax_tracker.sv
// tb_cmp_minmax_tracker: directed checks of the windowed min/max tracker.
// Build with CMP_MINMAX_FLUSH_EN defined to also exercise the early-close flush.
module tb_cmp_minmax_tracker;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic       signed_mode;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_min;
  logic [5:0] out_max;
  logic       out_all_eq;
  logic [7:0] out_count;
  logic       out_signed;

  int vectors;
  int miscompares;

  cmp_minmax_tracker #(.WIDTH(6), .WINDOW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef CMP_MINMAX_FLUSH_EN
    .flush      (flush),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .signed_mode(signed_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_min    (out_min),
    .out_max    (out_max),
    .out_all_eq (out_all_eq),
    .out_count  (out_count),
    .out_signed (out_signed)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison with failure reporting
  task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Full result check, done while the result is presented
  task automatic checkOutput(input string tag, input logic [5:0] emin, input logic [5:0] emax,
                             input logic eeq, input logic [7:0] ecnt, input logic esgn);
    checkVal({tag, ".valid"}, {7'd0, out_valid}, 8'd1);
    checkVal({tag, ".min"}, {2'd0, out_min}, {2'd0, emin});
    checkVal({tag, ".max"}, {2'd0, out_max}, {2'd0, emax});
    checkVal({tag, ".all_eq"}, {7'd0, out_all_eq}, {7'd0, eeq});
    checkVal({tag, ".count"}, out_count, ecnt);
    checkVal({tag, ".signed"}, {7'd0, out_signed}, {7'd0, esgn});
  endtask

  // Present one sample from a negedge and wait (bounded) for it to be accepted
  task automatic applyStimulus(input logic [5:0] data, input logic smode, input logic fl);
    int waited;
    @(negedge clk);
    in_valid    = 1'b1;
    in_data     = data;
    signed_mode = smode;
    flush       = fl;
    waited      = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkVal("accept_timeout", 8'd0, 8'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Take the presented result and confirm the handshake completes
  task automatic deliver(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkVal({tag, ".valid_drop"}, {7'd0, out_valid}, 8'd0);
    checkVal({tag, ".ready_back"}, {7'd0, in_ready}, 8'd1);
  endtask

  initial begin
    logic [5:0] win1 [8];
    logic [5:0] ties [8];
    logic [5:0] fresh [8];
    win1  = '{6'd5, 6'd63, 6'd0, 6'd32, 6'd7, 6'd7, 6'd1, 6'd2};
    ties  = '{6'd9, 6'd3, 6'd3, 6'd9, 6'd5, 6'd5, 6'd5, 6'd5};
    fresh = '{6'd10, 6'd20, 6'd30, 6'd40, 6'd50, 6'd60, 6'd11, 6'd12};
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 6'd0;
    signed_mode = 1'b0;
    out_ready   = 1'b0;

    repeat (2) @(negedge clk);
    checkVal("reset.valid", {7'd0, out_valid}, 8'd0);
    checkVal("reset.min", {2'd0, out_min}, 8'd0);
    checkVal("reset.count", out_count, 8'd0);
    checkVal("reset.in_ready", {7'd0, in_ready}, 8'd1);
    rst_n = 1'b1;

    $display("[TB] unsigned window");
    for (int i = 0; i < 8; i++) applyStimulus(win1[i], 1'b0, 1'b0);
    checkOutput("unsigned", 6'd0, 6'd63, 1'b0, 8'd8, 1'b0);
    deliver("unsigned");

    $display("[TB] signed window, mode toggled mid-window");
    for (int i = 0; i < 8; i++) applyStimulus(win1[i], (i == 0) ? 1'b1 : 1'b0, 1'b0);
    checkOutput("signed", 6'd32, 6'd7, 1'b0, 8'd8, 1'b1);
    deliver("signed");

    $display("[TB] all-equal window");
    for (int i = 0; i < 8; i++) applyStimulus(6'd17, 1'b0, 1'b0);
    checkOutput("all_eq", 6'd17, 6'd17, 1'b1, 8'd8, 1'b0);
    deliver("all_eq");

    $display("[TB] ties window with backpressure");
    for (int i = 0; i < 8; i++) applyStimulus(ties[i], 1'b0, 1'b0);
    checkOutput("ties", 6'd3, 6'd9, 1'b0, 8'd8, 1'b0);
    in_valid = 1'b1;
    in_data  = 6'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkVal("bp.in_ready", {7'd0, in_ready}, 8'd0);
      checkVal("bp.min", {2'd0, out_min}, 8'd3);
      checkVal("bp.max", {2'd0, out_max}, 8'd9);
      checkVal("bp.valid", {7'd0, out_valid}, 8'd1);
    end
    in_valid = 1'b0;
    deliver("bp");

    $display("[TB] reset mid-window");
    for (int i = 0; i < 4; i++) applyStimulus(6'd33, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkVal("midrst.valid", {7'd0, out_valid}, 8'd0);
    checkVal("midrst.min", {2'd0, out_min}, 8'd0);
    checkVal("midrst.max", {2'd0, out_max}, 8'd0);
    checkVal("midrst.count", out_count, 8'd0);
    checkVal("midrst.all_eq", {7'd0, out_all_eq}, 8'd0);
    checkVal("midrst.in_ready", {7'd0, in_ready}, 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(fresh[i], 1'b0, 1'b0);
    checkOutput("fresh", 6'd10, 6'd60, 1'b0, 8'd8, 1'b0);
    deliver("fresh");

`ifdef CMP_MINMAX_FLUSH_EN
    $display("[TB] flush closes window early");
    applyStimulus(6'd4, 1'b0, 1'b0);
    applyStimulus(6'd60, 1'b0, 1'b0);
    applyStimulus(6'd2, 1'b0, 1'b1);
    checkOutput("flush", 6'd2, 6'd60, 1'b0, 8'd3, 1'b0);
    deliver("flush");
    applyStimulus(6'd9, 1'b1, 1'b1);
    checkOutput("flush1", 6'd9, 6'd9, 1'b1, 8'd1, 1'b1);
    deliver("flush1");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
